// File: rtl/modmul_interleaved_if.sv
// modmul_interleaved_if: request/response bundle for the interleaved modular multiplier
interface modmul_interleaved_if #(parameter int WIDTH = 64);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    modport master (output start, a, b, n, input busy, done, err, result);
    modport slave  (input start, a, b, n, output busy, done, err, result);
endinterface

// File: rtl/modmul_interleaved.sv
// modmul_interleaved: sequential MSB-first interleaved (a*b) mod n, one bit of b per clock
module modmul_interleaved #(parameter int WIDTH = 64) (
    input logic             clk,
    input logic             rst_n,
    modmul_interleaved_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, n_q, r_q, result_q;
    logic [IW-1:0]    i_q;
    logic             busy_q, done_q, err_q;
    logic [WIDTH+1:0] n_x, t0, t1;
    logic [WIDTH-1:0] t2;
    logic             bad;
    // r < n keeps 2r + a below 3n, so two conditional subtractions always finish the reduction
    always_comb begin
        n_x = {2'b00, n_q};
        t0  = {1'b0, r_q, 1'b0} + (b_q[i_q] ? {2'b00, a_q} : '0);
        t1  = t0 >= n_x ? t0 - n_x : t0;
        t2  = WIDTH'(t1 >= n_x ? t1 - n_x : t1);
        bad = bus.n == '0 || bus.a >= bus.n || bus.b >= bus.n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    a_q <= bus.a;
                    b_q <= bus.b;
                    n_q <= bus.n;
                    if (bad) begin
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else begin
                        r_q     <= '0;
                        i_q     <= IW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
            end else begin
                r_q <= t2;
                i_q <= i_q - 1'b1;
                if (i_q == '0) begin
                    result_q <= t2;
                    err_q    <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            end
        end
    end
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_modmul_interleaved.sv
// tb_modmul_interleaved: randomized check of modmul_interleaved against a cycle-level behavioural model
module tb_modmul_interleaved;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    modmul_interleaved_if #(.WIDTH(W)) bus ();
    modmul_interleaved #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_res = '0, m_pend = '0;
    int           m_cnt = 0;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, y, m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return W'(p % {{W{1'b0}}, m});
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes WIDTH edges later; invalid operands answer on the start edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_res = '0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_err = 1'b0; m_res = m_pend;
                end
            end else if (bus.start) begin
                if (bus.n == 0 || bus.a >= bus.n || bus.b >= bus.n) begin
                    m_done = 1'b1; m_err = 1'b1; m_res = '0;
                end else begin
                    m_busy = 1'b1; m_cnt = W; m_pend = mulmod(bus.a, bus.b, bus.n);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", W'(bus.busy), W'(m_busy));
        check("done", W'(bus.done), W'(m_done));
        check("err", W'(bus.err), W'(m_err));
        check("result", bus.result, m_res);
    end

    task automatic go(input logic [W-1:0] av, bv, nv);
        bus.a = av; bus.b = bv; bus.n = nv; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!bus.done && k < 200);
        if (!bus.done) check("done_timeout", W'(k), W'(W));
    endtask

    initial begin
        int k;
        logic [W-1:0] av, bv, nv;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(bus.busy), 0);
        check("rst_result", bus.result, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        go(5, 7, 11);
        wait_done(k);
        check("small_latency", W'(k), 64);
        check("small_result", bus.result, 2);
        check("small_err", W'(bus.err), 0);
        nv = 64'hFFFF_FFFF_FFFF_FFC5;
        go(nv - 1, nv - 1, nv);
        wait_done(k);
        check("large_result", bus.result, 1);
        @(posedge clk); #1;
        go(1, 1, 0);
        check("n0_done", W'(bus.done), 1);
        check("n0_err", W'(bus.err), 1);
        check("n0_busy", W'(bus.busy), 0);
        check("n0_result", bus.result, 0);
        @(posedge clk); #1;
        go(11, 3, 11);
        check("aeqn_done", W'(bus.done), 1);
        check("aeqn_err", W'(bus.err), 1);
        @(posedge clk); #1;
        go(0, 0, 1);
        wait_done(k);
        check("n1_result", bus.result, 0);
        check("n1_err", W'(bus.err), 0);
        go(3, 4, 13);
        repeat (9) @(posedge clk);
        #1 bus.a = 1; bus.b = 1; bus.n = 13; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(k);
        check("ignored_latency", W'(k + 10), 64);
        check("ignored_result", bus.result, 12);
        go(3, 4, 13);
        repeat (5) @(posedge clk);
        #1 bus.a = 2; bus.b = 6; bus.n = 7; bus.start = 1'b1;
        wait_done(k);
        check("b2b_first", bus.result, 12);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(k);
        check("b2b_latency", W'(k), 64);
        check("b2b_result", bus.result, 5);
        go(5, 7, 11);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", W'(bus.busy), 0);
        check("abort_done", W'(bus.done), 0);
        check("abort_result", bus.result, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        go(5, 7, 11);
        wait_done(k);
        check("after_reset_latency", W'(k), 64);
        check("after_reset_result", bus.result, 2);
        go(9, 10, 17);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1 bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.n = {$urandom, $urandom};
            @(negedge clk);
        end while (!bus.done && k < 200);
        check("stable_latency", W'(k), 64);
        check("stable_result", bus.result, 5);
        for (int i = 0; i < 1000; i++) begin
            nv = (i % 4 == 0) ? W'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if (nv == 0) nv = 1;
            av = (i % 50 == 0) ? '0 : {$urandom, $urandom} % nv;
            bv = {$urandom, $urandom} % nv;
            go(av, bv, nv);
            wait_done(k);
            check("rand_latency", W'(k), 64);
            check("rand_result", bus.result, mulmod(av, bv, nv));
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
